// File: rtl/axi_pkg.sv
// Shared AXI encodings, responder FSM state types and a constant-safe clog2.
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/simple_dp_ram.sv
// Backing store: one byte-enabled write port, one synchronous read port (1-cycle latency).
// A same-address read and write in one cycle return the previous contents.
module simple_dp_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_W     = 12
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    if (rd_en) rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_cube_mem_responder.sv
// AXI4 slave over a word-addressed RAM window: independent read/write FSMs, one burst in flight per direction.
// Writes take one beat per cycle; reads return one beat every two cycles, first rvalid two cycles after AR.
module axi_cube_mem_responder
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_AW     = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W  = DATA_WIDTH / 8;
  localparam int BYTE_SH = clog2(STRB_W);
  // One spare bit so index increments past the top of the address space never wrap into the window.
  localparam int IDX_W   = ADDR_WIDTH + 1;
  localparam logic [IDX_W-1:0] DEPTH     = IDX_W'(2**MEM_AW);
  localparam logic [2:0]       FULL_SIZE = 3'(BYTE_SH);

  function automatic logic [IDX_W-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return {1'b0, off} >> BYTE_SH;
  endfunction

  w_state_e              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [IDX_W-1:0]      w_idx_q, w_idx_d;
  logic [7:0]            w_len_q, w_len_d;
  logic [8:0]            w_cnt_q, w_cnt_d;
  logic                  w_err_q, w_err_d;

  r_state_e              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [IDX_W-1:0]      r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [8:0]            r_cnt_q, r_cnt_d;
  logic                  r_err_q, r_err_d;

  logic                  w_last, w_in_win, r_last, r_in_win;
  logic                  ram_we, ram_re;
  logic [MEM_AW-1:0]     ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  simple_dp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (MEM_AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (wdata),
    .wr_be   (wstrb),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_cnt_d   = w_cnt_q;
    w_err_d   = w_err_q;
    awready   = 1'b0;
    wready    = 1'b0;
    bvalid    = 1'b0;
    bresp     = RESP_OKAY;
    ram_we    = 1'b0;
    ram_waddr = w_idx_q[MEM_AW-1:0];
    w_last    = (w_cnt_q == {1'b0, w_len_q});
    w_in_win  = (w_idx_q < DEPTH);
    case (w_state_q)
      W_IDLE: begin
        awready = 1'b1;
        if (awvalid) begin
          w_id_d    = awid;
          w_idx_d   = word_index(awaddr);
          w_len_d   = awlen;
          w_cnt_d   = '0;
          w_err_d   = (awburst != BURST_INCR) || (awsize != FULL_SIZE);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          ram_we  = w_in_win && !w_err_q;
          w_idx_d = w_idx_q + IDX_W'(1);
          w_cnt_d = w_cnt_q + 9'd1;
          // Beat count, not wlast, closes the burst; a disagreeing wlast only poisons the response.
          if (!w_in_win || (wlast != w_last)) w_err_d = 1'b1;
          if (w_last) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = w_err_q ? RESP_SLVERR : RESP_OKAY;
        if (bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_err_d   = r_err_q;
    arready   = 1'b0;
    rvalid    = 1'b0;
    rlast     = 1'b0;
    rresp     = RESP_OKAY;
    rdata     = '0;
    ram_re    = 1'b0;
    ram_raddr = r_idx_q[MEM_AW-1:0];
    r_last    = (r_cnt_q == {1'b0, r_len_q});
    r_in_win  = (r_idx_q < DEPTH);
    case (r_state_q)
      R_IDLE: begin
        arready = 1'b1;
        if (arvalid) begin
          r_id_d    = arid;
          r_idx_d   = word_index(araddr);
          r_len_d   = arlen;
          r_cnt_d   = '0;
          r_err_d   = (arburst != BURST_INCR) || (arsize != FULL_SIZE);
          r_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        ram_re    = r_in_win && !r_err_q;
        r_state_d = R_DATA;
      end
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = r_last;
        if (r_err_q || !r_in_win) rresp = RESP_SLVERR;
        else                      rdata = ram_rdata;
        if (rready) begin
          if (r_last) begin
            r_state_d = R_IDLE;
          end else begin
            r_idx_d   = r_idx_q + IDX_W'(1);
            r_cnt_d   = r_cnt_q + 9'd1;
            r_state_d = R_FETCH;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign bid = w_id_q;
  assign rid = r_id_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
      r_state_q <= R_IDLE;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      r_err_q   <= r_err_d;
    end
  end

endmodule

// File: tb/tb_axi_cube_mem_responder.sv
// Scoreboarded bench for axi_cube_mem_responder: expected B/R responses queued at issue, checked at handshake.
module tb_axi_cube_mem_responder;

  localparam int DEPTH = 4096;
  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] FIXD = 2'b00;
  localparam logic [1:0] WRAP = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  awid = '0, arid = '0, bid, rid;
  logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, bready = 1'b1;
  logic        arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, rlast;

  always #5 clk = ~clk;

  axi_cube_mem_responder dut (
    .clk(clk), .rst(rst),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t      r_q[$];
  b_exp_t      b_q[$];
  logic [31:0] model [DEPTH];
  bit          mon_en = 1'b0;
  bit          stall_mode = 1'b0;
  bit          r_hold = 1'b0;
  logic [31:0] r_hold_dat = '0;
  r_exp_t      re;
  b_exp_t      be;

  always @(negedge clk) begin
    if (mon_en) begin
      if (r_hold) begin
        check_eq("r_hold_vld", rvalid, 1);
        check_eq("r_hold_dat", rdata, r_hold_dat);
      end
      if (rvalid && rready) begin
        if (r_q.size() == 0) check_eq("r_extra_beat", rvalid, 0);
        else begin
          re = r_q.pop_front();
          check_eq("rdata", rdata, re.data);
          check_eq("rresp", rresp, re.resp);
          check_eq("rlast", rlast, re.last);
          check_eq("rid", rid, re.id);
        end
      end
      if (bvalid && bready) begin
        if (b_q.size() == 0) check_eq("b_extra", bvalid, 0);
        else begin
          be = b_q.pop_front();
          check_eq("bresp", bresp, be.resp);
          check_eq("bid", bid, be.id);
        end
      end
      r_hold     = rvalid && !rready;
      r_hold_dat = rdata;
    end else begin
      r_hold = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rready = stall_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic expect_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input logic [31:0] base,
                              input logic [3:0] strb, input int early);
    b_exp_t      e;
    bit          err;
    int          idx;
    logic [31:0] d;
    err = (burst != INCR) || (early >= 0);
    for (int b = 0; b <= len; b++) begin
      idx = int'(addr >> 2) + b;
      if (idx >= DEPTH) err = 1'b1;
      else if (burst == INCR && early < 0) begin
        d = base + 32'(b);
        for (int k = 0; k < 4; k++) if (strb[k]) model[idx][k*8 +: 8] = d[k*8 +: 8];
      end
    end
    e.id   = id;
    e.resp = err ? 2'b10 : 2'b00;
    b_q.push_back(e);
  endtask

  task automatic expect_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                             input logic [1:0] burst);
    r_exp_t e;
    int     idx;
    bit     bad;
    for (int b = 0; b <= len; b++) begin
      idx    = int'(addr >> 2) + b;
      bad    = (burst != INCR) || (idx >= DEPTH);
      e.id   = id;
      e.data = bad ? 32'h0 : model[idx];
      e.resp = bad ? 2'b10 : 2'b00;
      e.last = (b == len);
      r_q.push_back(e);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [31:0] base,
                          input logic [3:0] strb, input int early);
    int n;
    @(posedge clk); #1;
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'd2; awburst = burst; awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < 400) begin @(negedge clk); n++; end
    check_eq("aw_accept", awready, 1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      wdata  = base + 32'(b);
      wstrb  = strb;
      wlast  = (early >= 0) ? (b == early) : (b == len);
      wvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!wready && n < 400) begin @(negedge clk); n++; end
      check_eq("w_accept", wready, 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst);
    int n;
    @(posedge clk); #1;
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'd2; arburst = burst; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 400) begin @(negedge clk); n++; end
    check_eq("ar_accept", arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((r_q.size() != 0 || b_q.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_left", r_q.size() + b_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_awready", awready, 1);
    check_eq("rst_arready", arready, 1);
    check_eq("rst_wready", wready, 0);
    check_eq("rst_bvalid", bvalid, 0);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_rlast", rlast, 0);
    check_eq("rst_bresp", bresp, 0);
    check_eq("rst_rresp", rresp, 0);
    check_eq("rst_bid", bid, 0);
    check_eq("rst_rid", rid, 0);
    check_eq("rst_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // Basic 4-beat write and read-back
    expect_write(4'h3, 32'h1000, 3, INCR, 32'h1, 4'hF, -1);
    do_write(4'h3, 32'h1000, 3, INCR, 32'h1, 4'hF, -1);
    drain();
    expect_read(4'h5, 32'h1000, 3, INCR);
    do_read(4'h5, 32'h1000, 3, INCR);
    drain();

    // Partial byte strobes merge into existing word
    expect_write(4'h1, 32'h1100, 0, INCR, 32'h1122_3344, 4'hF, -1);
    do_write(4'h1, 32'h1100, 0, INCR, 32'h1122_3344, 4'hF, -1);
    expect_write(4'h2, 32'h1100, 0, INCR, 32'hAABB_CCDD, 4'b0101, -1);
    do_write(4'h2, 32'h1100, 0, INCR, 32'hAABB_CCDD, 4'b0101, -1);
    drain();
    expect_read(4'h6, 32'h1100, 0, INCR);
    do_read(4'h6, 32'h1100, 0, INCR);
    drain();

    // 256-beat bursts, read side with random rready stalls
    expect_write(4'h4, 32'h0800, 255, INCR, 32'h5000_0000, 4'hF, -1);
    do_write(4'h4, 32'h0800, 255, INCR, 32'h5000_0000, 4'hF, -1);
    drain();
    stall_mode = 1'b1;
    expect_read(4'h7, 32'h0800, 255, INCR);
    do_read(4'h7, 32'h0800, 255, INCR);
    drain();
    stall_mode = 1'b0;

    // Burst running off the top of the window
    expect_write(4'h8, 32'h0000, 0, INCR, 32'hCAFE_F00D, 4'hF, -1);
    do_write(4'h8, 32'h0000, 0, INCR, 32'hCAFE_F00D, 4'hF, -1);
    expect_write(4'h9, 32'h3FFC, 1, INCR, 32'h7777_0000, 4'hF, -1);
    do_write(4'h9, 32'h3FFC, 1, INCR, 32'h7777_0000, 4'hF, -1);
    drain();
    expect_read(4'hA, 32'h3FFC, 1, INCR);
    do_read(4'hA, 32'h3FFC, 1, INCR);
    drain();
    expect_read(4'hB, 32'h0000, 0, INCR);
    do_read(4'hB, 32'h0000, 0, INCR);
    drain();

    // Protocol errors: FIXED burst, early wlast, WRAP read
    expect_write(4'hC, 32'h2000, 0, FIXD, 32'h1234_5678, 4'hF, -1);
    do_write(4'hC, 32'h2000, 0, FIXD, 32'h1234_5678, 4'hF, -1);
    expect_write(4'hD, 32'h3000, 3, INCR, 32'h0BAD_0000, 4'hF, 1);
    do_write(4'hD, 32'h3000, 3, INCR, 32'h0BAD_0000, 4'hF, 1);
    drain();
    expect_read(4'hE, 32'h1000, 3, WRAP);
    do_read(4'hE, 32'h1000, 3, WRAP);
    drain();

    // Same-word read and write on the same edge: read sees old data
    expect_read(4'h9, 32'h1000, 0, INCR);
    expect_write(4'hA, 32'h1000, 0, INCR, 32'h0000_0099, 4'hF, -1);
    fork
      do_read(4'h9, 32'h1000, 0, INCR);
      do_write(4'hA, 32'h1000, 0, INCR, 32'h0000_0099, 4'hF, -1);
    join
    drain();

    // Reset in the middle of a read burst
    mon_en = 1'b0;
    do_read(4'hB, 32'h1000, 7, INCR);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("midrst_rvalid", rvalid, 0);
    check_eq("midrst_arready", arready, 1);
    check_eq("midrst_rlast", rlast, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    mon_en = 1'b1;
    expect_read(4'hC, 32'h1000, 1, INCR);
    do_read(4'hC, 32'h1000, 1, INCR);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
